// File: rtl/axi_lite_rr_arbiter_if.sv
// axi_lite_if: AXI-lite bundle used on both sides of axi_lite_rr_arbiter.
// Both modports are written from the arbiter's side of the link:
//   MASTER - the arbiter port that faces an upstream master
//            (takes AW/W/AR VALID+payload, BREADY, RREADY; returns READY/B/R)
//   SLAVE  - the arbiter port that faces the downstream slave
//            (drives AW/W/AR VALID+payload, BREADY, RREADY; takes READY/B/R)
interface axi_lite_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                      AWVALID;
  logic                      AWREADY;
  logic [ADDR_WIDTH-1:0]     AWADDR;
  logic                      WVALID;
  logic                      WREADY;
  logic [DATA_WIDTH-1:0]     WDATA;
  logic [DATA_WIDTH/8-1:0]   WSTRB;
  logic                      BVALID;
  logic                      BREADY;
  logic [1:0]                BRESP;
  logic                      ARVALID;
  logic                      ARREADY;
  logic [ADDR_WIDTH-1:0]     ARADDR;
  logic                      RVALID;
  logic                      RREADY;
  logic [DATA_WIDTH-1:0]     RDATA;
  logic [1:0]                RRESP;

  modport MASTER (
    input  AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

  modport SLAVE (
    output AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );
endinterface

// File: rtl/axi_lite_rr_arbiter.sv
// axi_lite_rr_arbiter: N:1 AXI-lite arbiter with independent read and write paths.
// A grant is held from address issue until the response handshake, so transactions
// never interleave on a path and responses always return to their originator.
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   m_if[N]       master-facing ports (axi_lite_if.MASTER)
//   s_if          slave-facing port   (axi_lite_if.SLAVE)
//   wr_grant_idx  write-path owner (valid while wr_busy)
//   rd_grant_idx  read-path owner  (valid while rd_busy)
//   wr_busy       write path not idle
//   rd_busy       read path not idle
// Build option: define AXI_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins,
// no rotating pointers); otherwise round-robin starting after the last owner.
module axi_lite_rr_arbiter #(
  parameter  int unsigned NUM_MASTERS = 4,
  parameter  int unsigned ADDR_WIDTH  = 32,
  parameter  int unsigned DATA_WIDTH  = 32,
  localparam int unsigned IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic             clk,
  input  logic             rst,
  axi_lite_if.MASTER       m_if [0:NUM_MASTERS-1],
  axi_lite_if.SLAVE        s_if,
  output logic [IDX_W-1:0] wr_grant_idx,
  output logic [IDX_W-1:0] rd_grant_idx,
  output logic             wr_busy,
  output logic             rd_busy
);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;

  wr_state_t        r_wr_state;
  rd_state_t        r_rd_state;
  logic [IDX_W-1:0] r_wr_gnt;
  logic [IDX_W-1:0] r_rd_gnt;
  logic             r_aw_done;
  logic             r_w_done;

  // Flattened master-side inputs (interface arrays only take constant indices)
  logic [NUM_MASTERS-1:0] w_awvalid, w_wvalid, w_bready, w_arvalid, w_rready;
  logic [ADDR_WIDTH-1:0]  w_awaddr [NUM_MASTERS];
  logic [DATA_WIDTH-1:0]  w_wdata  [NUM_MASTERS];
  logic [DATA_WIDTH/8-1:0] w_wstrb [NUM_MASTERS];
  logic [ADDR_WIDTH-1:0]  w_araddr [NUM_MASTERS];

  logic [IDX_W-1:0] w_wr_base, w_rd_base, w_wr_win, w_rd_win;
  logic w_s_awvalid, w_s_wvalid, w_s_arvalid;
  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] g);
    return (g == IDX_W'(NUM_MASTERS - 1)) ? '0 : g + 1'b1;
  endfunction

  // First requester found scanning base, base+1, ... with wrap-around
  function automatic logic [IDX_W-1:0] pick(input logic [NUM_MASTERS-1:0] req,
                                            input logic [IDX_W-1:0]       base);
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] j;
    logic             found;
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      j = IDX_W'((32'(base) + k) % NUM_MASTERS);
      if (!found && req[j]) begin
        win   = j;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_m
    assign w_awvalid[gi] = m_if[gi].AWVALID;
    assign w_wvalid[gi]  = m_if[gi].WVALID;
    assign w_bready[gi]  = m_if[gi].BREADY;
    assign w_arvalid[gi] = m_if[gi].ARVALID;
    assign w_rready[gi]  = m_if[gi].RREADY;
    assign w_awaddr[gi]  = m_if[gi].AWADDR;
    assign w_wdata[gi]   = m_if[gi].WDATA;
    assign w_wstrb[gi]   = m_if[gi].WSTRB;
    assign w_araddr[gi]  = m_if[gi].ARADDR;

    assign m_if[gi].AWREADY = (r_wr_state == W_ADDR) && (r_wr_gnt == IDX_W'(gi)) &&
                              s_if.AWREADY && !r_aw_done;
    assign m_if[gi].WREADY  = (r_wr_state == W_ADDR) && (r_wr_gnt == IDX_W'(gi)) &&
                              s_if.WREADY && !r_w_done;
    assign m_if[gi].BVALID  = (r_wr_state == W_RESP) && (r_wr_gnt == IDX_W'(gi)) &&
                              s_if.BVALID;
    assign m_if[gi].BRESP   = s_if.BRESP;
    assign m_if[gi].ARREADY = (r_rd_state == R_ADDR) && (r_rd_gnt == IDX_W'(gi)) &&
                              s_if.ARREADY;
    assign m_if[gi].RVALID  = (r_rd_state == R_DATA) && (r_rd_gnt == IDX_W'(gi)) &&
                              s_if.RVALID;
    assign m_if[gi].RDATA   = s_if.RDATA;
    assign m_if[gi].RRESP   = s_if.RRESP;
  end

  // Payloads are selected by the registered grant only, never by live VALIDs
  assign w_s_awvalid  = (r_wr_state == W_ADDR) && w_awvalid[r_wr_gnt] && !r_aw_done;
  assign w_s_wvalid   = (r_wr_state == W_ADDR) && w_wvalid[r_wr_gnt] && !r_w_done;
  assign w_s_arvalid  = (r_rd_state == R_ADDR) && w_arvalid[r_rd_gnt];
  assign s_if.AWVALID = w_s_awvalid;
  assign s_if.AWADDR  = w_awaddr[r_wr_gnt];
  assign s_if.WVALID  = w_s_wvalid;
  assign s_if.WDATA   = w_wdata[r_wr_gnt];
  assign s_if.WSTRB   = w_wstrb[r_wr_gnt];
  assign s_if.BREADY  = (r_wr_state == W_RESP) && w_bready[r_wr_gnt];
  assign s_if.ARVALID = w_s_arvalid;
  assign s_if.ARADDR  = w_araddr[r_rd_gnt];
  assign s_if.RREADY  = (r_rd_state == R_DATA) && w_rready[r_rd_gnt];

  assign w_aw_hs = w_s_awvalid && s_if.AWREADY;
  assign w_w_hs  = w_s_wvalid && s_if.WREADY;
  assign w_b_hs  = (r_wr_state == W_RESP) && s_if.BVALID && w_bready[r_wr_gnt];
  assign w_ar_hs = w_s_arvalid && s_if.ARREADY;
  assign w_r_hs  = (r_rd_state == R_DATA) && s_if.RVALID && w_rready[r_rd_gnt];

`ifdef AXI_ARB_FIXED_PRIO_EN
  assign w_wr_base = '0;
  assign w_rd_base = '0;
`else
  logic [IDX_W-1:0] r_wr_ptr;
  logic [IDX_W-1:0] r_rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_b_hs) r_wr_ptr <= next_idx(r_wr_gnt);
      if (w_r_hs) r_rd_ptr <= next_idx(r_rd_gnt);
    end
  end

  assign w_wr_base = r_wr_ptr;
  assign w_rd_base = r_rd_ptr;
`endif

  assign w_wr_win = pick(w_awvalid | w_wvalid, w_wr_base);
  assign w_rd_win = pick(w_arvalid, w_rd_base);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_state <= W_IDLE;
      r_wr_gnt   <= '0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else begin
      case (r_wr_state)
        W_IDLE: begin
          if (|(w_awvalid | w_wvalid)) begin
            r_wr_gnt   <= w_wr_win;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_wr_state <= W_ADDR;
          end
        end
        W_ADDR: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
          // AW and W may complete in either order or together
          if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) r_wr_state <= W_RESP;
        end
        W_RESP: begin
          if (w_b_hs) r_wr_state <= W_IDLE;
        end
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_state <= R_IDLE;
      r_rd_gnt   <= '0;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          if (|w_arvalid) begin
            r_rd_gnt   <= w_rd_win;
            r_rd_state <= R_ADDR;
          end
        end
        R_ADDR: if (w_ar_hs) r_rd_state <= R_DATA;
        R_DATA: if (w_r_hs)  r_rd_state <= R_IDLE;
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  assign wr_grant_idx = r_wr_gnt;
  assign rd_grant_idx = r_rd_gnt;
  assign wr_busy      = (r_wr_state != W_IDLE);
  assign rd_busy      = (r_rd_state != R_IDLE);

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// Directed bench for axi_lite_rr_arbiter (4 masters). A transaction-level model
// predicts every arbiter output each cycle; literal checks pin key scenarios.
// Honours AXI_ARB_FIXED_PRIO_EN for the expected grant order.
module tb_axi_lite_rr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_if [0:3] ();
  axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_if ();
  logic [1:0] wr_grant_idx, rd_grant_idx;
  logic       wr_busy, rd_busy;

  axi_lite_rr_arbiter #(.NUM_MASTERS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .m_if(m_if), .s_if(s_if),
    .wr_grant_idx(wr_grant_idx), .rd_grant_idx(rd_grant_idx),
    .wr_busy(wr_busy), .rd_busy(rd_busy)
  );

  // master-side stimulus and observed DUT outputs
  logic [3:0]  m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready;
  logic [31:0] m_awaddr [4];
  logic [31:0] m_wdata  [4];
  logic [31:0] m_araddr [4];
  logic [3:0]  d_awready, d_wready, d_bvalid, d_arready, d_rvalid;
  logic [1:0]  d_bresp [4];
  logic [31:0] d_rdata [4];
  // slave-side stimulus
  logic        s_awready, s_wready, s_arready, s_bvalid, s_rvalid;
  logic [31:0] s_rdata;
  logic [1:0]  s_bresp;

  for (genvar gi = 0; gi < 4; gi++) begin : g_m
    assign m_if[gi].AWVALID = m_awvalid[gi];
    assign m_if[gi].AWADDR  = m_awaddr[gi];
    assign m_if[gi].WVALID  = m_wvalid[gi];
    assign m_if[gi].WDATA   = m_wdata[gi];
    assign m_if[gi].WSTRB   = 4'hF;
    assign m_if[gi].BREADY  = m_bready[gi];
    assign m_if[gi].ARVALID = m_arvalid[gi];
    assign m_if[gi].ARADDR  = m_araddr[gi];
    assign m_if[gi].RREADY  = m_rready[gi];
    assign d_awready[gi]    = m_if[gi].AWREADY;
    assign d_wready[gi]     = m_if[gi].WREADY;
    assign d_bvalid[gi]     = m_if[gi].BVALID;
    assign d_bresp[gi]      = m_if[gi].BRESP;
    assign d_arready[gi]    = m_if[gi].ARREADY;
    assign d_rvalid[gi]     = m_if[gi].RVALID;
    assign d_rdata[gi]      = m_if[gi].RDATA;
  end
  assign s_if.AWREADY = s_awready;
  assign s_if.WREADY  = s_wready;
  assign s_if.BVALID  = s_bvalid;
  assign s_if.BRESP   = s_bresp;
  assign s_if.ARREADY = s_arready;
  assign s_if.RVALID  = s_rvalid;
  assign s_if.RDATA   = s_rdata;
  assign s_if.RRESP   = 2'b00;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // transaction-level model: phase 0 idle, 1 address, 2 response
  int mw_ph, mw_own, mw_next, mr_ph, mr_own, mr_next;
  bit mw_awd, mw_wd;
  // handshakes that will complete at the coming rising edge
  logic [3:0]  f_aw, f_w, f_b, f_ar, f_r;
  logic        fs_aw, fs_w, fs_b, fs_ar, fs_r;
  logic [31:0] f_rdata [4];
  logic [1:0]  f_bresp [4];
  // bookkeeping
  int          bcnt [4];
  int          rcnt [4];
  logic [31:0] last_rdata [4];
  logic [1:0]  last_bresp [4];
  int          aw_hs_cyc [4];
  int          w_hs_cyc [4];
  logic [3:0]  auto_wr;
  int          pend_aw, pend_w, pend_ar, b_hold, cyc;
  int          wr_log [$];
  logic        prev_wr_busy;

  function automatic int pick(input logic [3:0] req, input int base);
    int b;
    int j;
    b = base;
`ifdef AXI_ARB_FIXED_PRIO_EN
    b = 0;
`endif
    for (int k = 0; k < 4; k++) begin
      j = (b + k) % 4;
      if (req[j[1:0]]) return j;
    end
    return 0;
  endfunction

  task automatic model_reset();
    mw_ph = 0; mw_own = 0; mw_next = 0; mw_awd = 0; mw_wd = 0;
    mr_ph = 0; mr_own = 0; mr_next = 0;
  endtask

  // Compare at the falling edge, then advance the model to the next rising edge
  task automatic compare_step();
    logic [1:0] wo, ro;
    logic       e_aw, e_w, e_ar;
    logic [3:0] e_awr, e_wr, e_bv, e_arr, e_rv;
    cyc++;
    if (rst) begin
      chk("rst_s_valid", 32'({s_if.AWVALID, s_if.WVALID, s_if.ARVALID}), 32'(0));
      chk("rst_s_ready", 32'({s_if.BREADY, s_if.RREADY}), 32'(0));
      chk("rst_m_ready", 32'({d_awready, d_wready, d_arready}), 32'(0));
      chk("rst_m_valid", 32'({d_bvalid, d_rvalid}), 32'(0));
      chk("rst_busy", 32'({wr_busy, rd_busy}), 32'(0));
      model_reset();
      {f_aw, f_w, f_b, f_ar, f_r} = '0;
      {fs_aw, fs_w, fs_b, fs_ar, fs_r} = '0;
      prev_wr_busy = 1'b0;
      return;
    end
    wo = 2'(mw_own);
    ro = 2'(mr_own);
    e_aw  = (mw_ph == 1) && m_awvalid[wo] && !mw_awd;
    e_w   = (mw_ph == 1) && m_wvalid[wo] && !mw_wd;
    e_ar  = (mr_ph == 1) && m_arvalid[ro];
    e_awr = '0; e_wr = '0; e_bv = '0; e_arr = '0; e_rv = '0;
    if (mw_ph == 1) begin
      e_awr[wo] = s_awready && !mw_awd;
      e_wr[wo]  = s_wready && !mw_wd;
    end
    if (mw_ph == 2) e_bv[wo]  = s_bvalid;
    if (mr_ph == 1) e_arr[ro] = s_arready;
    if (mr_ph == 2) e_rv[ro]  = s_rvalid;

    chk("wr_busy", 32'(wr_busy), 32'(mw_ph != 0));
    chk("rd_busy", 32'(rd_busy), 32'(mr_ph != 0));
    if (mw_ph != 0) begin
      chk("wr_grant_idx", 32'(wr_grant_idx), 32'(mw_own));
      chk("s_awaddr", s_if.AWADDR, m_awaddr[wo]);
      chk("s_wdata", s_if.WDATA, m_wdata[wo]);
    end
    if (mr_ph != 0) begin
      chk("rd_grant_idx", 32'(rd_grant_idx), 32'(mr_own));
      chk("s_araddr", s_if.ARADDR, m_araddr[ro]);
    end
    chk("s_awvalid", 32'(s_if.AWVALID), 32'(e_aw));
    chk("s_wvalid", 32'(s_if.WVALID), 32'(e_w));
    chk("s_bready", 32'(s_if.BREADY), 32'((mw_ph == 2) && m_bready[wo]));
    chk("s_arvalid", 32'(s_if.ARVALID), 32'(e_ar));
    chk("s_rready", 32'(s_if.RREADY), 32'((mr_ph == 2) && m_rready[ro]));
    chk("m_awready", 32'(d_awready), 32'(e_awr));
    chk("m_wready", 32'(d_wready), 32'(e_wr));
    chk("m_bvalid", 32'(d_bvalid), 32'(e_bv));
    chk("m_arready", 32'(d_arready), 32'(e_arr));
    chk("m_rvalid", 32'(d_rvalid), 32'(e_rv));
    for (int unsigned ii = 0; ii < 4; ii++) begin
      chk("m_rdata_bcast", d_rdata[ii], s_rdata);
      chk("m_bresp_bcast", 32'(d_bresp[ii]), 32'(s_bresp));
    end

    f_aw = m_awvalid & d_awready;
    f_w  = m_wvalid & d_wready;
    f_b  = m_bready & d_bvalid;
    f_ar = m_arvalid & d_arready;
    f_r  = m_rready & d_rvalid;
    for (int unsigned ii = 0; ii < 4; ii++) begin
      f_rdata[ii] = d_rdata[ii];
      f_bresp[ii] = d_bresp[ii];
    end
    fs_aw = s_if.AWVALID && s_awready;
    fs_w  = s_if.WVALID && s_wready;
    fs_b  = s_bvalid && s_if.BREADY;
    fs_ar = s_if.ARVALID && s_arready;
    fs_r  = s_rvalid && s_if.RREADY;
    if (wr_busy && !prev_wr_busy) wr_log.push_back(int'(wr_grant_idx));
    prev_wr_busy = wr_busy;

    case (mw_ph)
      0: if (|(m_awvalid | m_wvalid)) begin
           mw_own = pick(m_awvalid | m_wvalid, mw_next);
           mw_ph = 1; mw_awd = 0; mw_wd = 0;
         end
      1: begin
           if (e_aw && s_awready) mw_awd = 1;
           if (e_w && s_wready) mw_wd = 1;
           if (mw_awd && mw_wd) mw_ph = 2;
         end
      default: if (s_bvalid && m_bready[wo]) begin
           mw_ph = 0; mw_next = (mw_own + 1) % 4;
         end
    endcase
    case (mr_ph)
      0: if (|m_arvalid) begin
           mr_own = pick(m_arvalid, mr_next);
           mr_ph = 1;
         end
      1: if (e_ar && s_arready) mr_ph = 2;
      default: if (s_rvalid && m_rready[ro]) begin
           mr_ph = 0; mr_next = (mr_own + 1) % 4;
         end
    endcase
  endtask

  // Just after the rising edge: masters and slave react to completed handshakes
  task automatic apply_bus();
    if (rst) begin
      m_awvalid = '0; m_wvalid = '0; m_arvalid = '0; auto_wr = '0;
      s_bvalid = 1'b0; s_rvalid = 1'b0;
      pend_aw = 0; pend_w = 0; pend_ar = 0; b_hold = 0;
      return;
    end
    for (int unsigned ii = 0; ii < 4; ii++) begin
      logic [1:0] i;
      i = 2'(ii);
      if (f_aw[i]) begin m_awvalid[i] = 1'b0; aw_hs_cyc[i] = cyc; end
      if (f_w[i])  begin m_wvalid[i]  = 1'b0; w_hs_cyc[i]  = cyc; end
      if (f_ar[i]) m_arvalid[i] = 1'b0;
      if (f_r[i]) begin rcnt[i]++; last_rdata[i] = f_rdata[i]; end
      if (f_b[i]) begin
        bcnt[i]++;
        last_bresp[i] = f_bresp[i];
        if (auto_wr[i]) begin
          m_awaddr[i] = m_awaddr[i] + 32'h10;
          m_wdata[i]  = m_wdata[i] + 32'h1;
          m_awvalid[i] = 1'b1; m_wvalid[i] = 1'b1;
        end
      end
    end
    if (fs_aw) pend_aw++;
    if (fs_w)  pend_w++;
    if (fs_ar) pend_ar++;
    if (fs_b)  s_bvalid = 1'b0;
    if (fs_r)  s_rvalid = 1'b0;
    if (b_hold > 0) b_hold--;
    else if (!s_bvalid && pend_aw > 0 && pend_w > 0) begin
      s_bvalid = 1'b1; pend_aw--; pend_w--;
    end
    if (!s_rvalid && pend_ar > 0) begin
      s_rvalid = 1'b1; s_rdata = 32'hDEADBEEF; pend_ar--;
    end
    {f_aw, f_w, f_b, f_ar, f_r} = '0;
    {fs_aw, fs_w, fs_b, fs_ar, fs_r} = '0;
  endtask

  task automatic tick();
    @(negedge clk);
    compare_step();
    @(posedge clk);
    #1;
    apply_bus();
  endtask

  task automatic wr_req(input logic [1:0] i, input logic [31:0] a, input logic [31:0] d);
    m_awaddr[i] = a; m_wdata[i] = d;
    m_awvalid[i] = 1'b1; m_wvalid[i] = 1'b1;
  endtask

  task automatic wait_b(input logic [1:0] i, input int target, input string name);
    int k;
    k = 0;
    while (bcnt[i] < target && k < 200) begin tick(); k++; end
    chk(name, 32'(bcnt[i]), 32'(target));
  endtask

  task automatic chk_log(input string name, input int e0, input int e1, input int e2, input int e3, input int n);
    int exp [4];
    exp = '{e0, e1, e2, e3};
    chk({name, "_len_ge"}, 32'(wr_log.size() >= n), 32'(1));
    for (int k = 0; k < n; k++)
      if (k < wr_log.size()) chk({name, "_grant"}, 32'(wr_log[k]), 32'(exp[k]));
  endtask

  initial begin
    int k;
    int b1, b3;
    m_awvalid = '0; m_wvalid = '0; m_arvalid = '0; m_bready = '1; m_rready = '1;
    for (int unsigned ii = 0; ii < 4; ii++) begin
      m_awaddr[ii] = '0; m_wdata[ii] = '0; m_araddr[ii] = '0;
      bcnt[ii] = 0; rcnt[ii] = 0; last_rdata[ii] = '0; last_bresp[ii] = 2'b11;
      aw_hs_cyc[ii] = 0; w_hs_cyc[ii] = 0;
      f_rdata[ii] = '0; f_bresp[ii] = '0;
    end
    s_awready = 1'b1; s_wready = 1'b1; s_arready = 1'b1;
    s_bvalid = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_bresp = 2'b00;
    auto_wr = '0; pend_aw = 0; pend_w = 0; pend_ar = 0; b_hold = 0; cyc = 0;
    prev_wr_busy = 1'b0;
    {f_aw, f_w, f_b, f_ar, f_r} = '0;
    {fs_aw, fs_w, fs_b, fs_ar, fs_r} = '0;
    model_reset();

    // reset state
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_wr_busy", 32'(wr_busy), 32'(0));
    chk("reset_rd_busy", 32'(rd_busy), 32'(0));
    chk("reset_grants", 32'({wr_grant_idx, rd_grant_idx}), 32'(0));

    // 1: m0 and m2 together; m0 re-requests after its B
    wr_log.delete();
    wr_req(2'd0, 32'h0000_1000, 32'hA000_0000);
    wr_req(2'd2, 32'h0000_2000, 32'hA200_0000);
    tick();
    chk("t1_first_grant", 32'(wr_grant_idx), 32'(0));
    wait_b(2'd0, 1, "t1_m0_b");
    wr_req(2'd0, 32'h0000_1100, 32'hA000_0001);
    wait_b(2'd2, 1, "t1_m2_b");
    wait_b(2'd0, 2, "t1_m0_b2");
`ifdef AXI_ARB_FIXED_PRIO_EN
    chk_log("t1", 0, 0, 2, 0, 3);
`else
    chk_log("t1", 0, 2, 0, 0, 3);
`endif

    // 2: m1 W three cycles ahead of AW
    m_wdata[1] = 32'h1111_2222; m_awaddr[1] = 32'h0000_3000;
    m_wvalid[1] = 1'b1;
    tick(); tick(); tick();
    m_awvalid[1] = 1'b1;
    wait_b(2'd1, 1, "t2_m1_b");
    chk("t2_w_before_aw", 32'(w_hs_cyc[1] < aw_hs_cyc[1]), 32'(1));
    chk("t2_others_b", 32'(bcnt[0] + bcnt[2] + bcnt[3]), 32'(3));

    // 3: slave stalls B; others wait without READY
    wr_log.delete();
    b_hold = 24;
    wr_req(2'd0, 32'h0000_4000, 32'hB000_0000);
    tick(); tick(); tick();
    wr_req(2'd2, 32'h0000_4200, 32'hB200_0000);
    wr_req(2'd3, 32'h0000_4300, 32'hB300_0000);
    for (int c = 0; c < 18; c++) begin
      tick();
      chk("t3_busy", 32'(wr_busy), 32'(1));
      chk("t3_owner", 32'(wr_grant_idx), 32'(0));
      chk("t3_s_awvalid", 32'(s_if.AWVALID), 32'(0));
      chk("t3_awready", 32'(d_awready), 32'(0));
    end
    wait_b(2'd0, 3, "t3_m0_b");
    wait_b(2'd2, 2, "t3_m2_b");
    wait_b(2'd3, 1, "t3_m3_b");
    chk_log("t3", 0, 2, 3, 0, 3);

    // 4: concurrent read by m3 and write by m1
    b_hold = 4;
    wr_req(2'd1, 32'h0000_5000, 32'hC100_0000);
    m_araddr[3] = 32'h0000_6000; m_arvalid[3] = 1'b1;
    tick();
    chk("t4_wr_owner", 32'(wr_grant_idx), 32'(1));
    chk("t4_rd_owner", 32'(rd_grant_idx), 32'(3));
    chk("t4_both_busy", 32'({wr_busy, rd_busy}), 32'(3));
    k = 0;
    while ((rcnt[3] < 1 || bcnt[1] < 2) && k < 100) begin tick(); k++; end
    chk("t4_rdata_m3", last_rdata[3], 32'hDEADBEEF);
    chk("t4_rcnt", 32'({rcnt[0][7:0], rcnt[1][7:0], rcnt[2][7:0], rcnt[3][7:0]}), 32'h0000_0001);
    chk("t4_bresp_m1", 32'(last_bresp[1]), 32'(0));

    // 5: asynchronous reset in W_RESP with a read stuck in R_ADDR
    b_hold = 10;
    s_arready = 1'b0;
    wr_req(2'd2, 32'h0000_7000, 32'hD200_0000);
    m_araddr[0] = 32'h0000_7800; m_arvalid[0] = 1'b1;
    tick(); tick(); tick();
    chk("t5_pre_busy", 32'({wr_busy, rd_busy}), 32'(3));
    #2 rst = 1'b1;
    #1;
    chk("t5_async_s", 32'({s_if.AWVALID, s_if.WVALID, s_if.BREADY, s_if.ARVALID, s_if.RREADY}), 32'(0));
    chk("t5_async_m", 32'({d_awready, d_wready, d_bvalid, d_arready, d_rvalid}), 32'(0));
    chk("t5_async_busy", 32'({wr_busy, rd_busy}), 32'(0));
    tick();
    rst = 1'b0;
    s_arready = 1'b1;
    wr_log.delete();
    b1 = bcnt[1]; b3 = bcnt[3];
    wr_req(2'd1, 32'h0000_8100, 32'hE100_0000);
    wr_req(2'd3, 32'h0000_8300, 32'hE300_0000);
    wait_b(2'd1, b1 + 1, "t5_m1_b");
    wait_b(2'd3, b3 + 1, "t5_m3_b");
    chk_log("t5", 1, 3, 0, 0, 2);

    // 6: m0 and m1 request continuously
    wr_log.delete();
    auto_wr = 4'b0011;
    wr_req(2'd0, 32'h0000_9000, 32'hF000_0000);
    wr_req(2'd1, 32'h0000_9100, 32'hF100_0000);
    k = 0;
    while (wr_log.size() < 4 && k < 200) begin tick(); k++; end
    auto_wr = '0;
`ifdef AXI_ARB_FIXED_PRIO_EN
    chk_log("t6", 0, 0, 0, 0, 4);
`else
    chk_log("t6", 0, 1, 0, 1, 4);
`endif
    k = 0;
    while ((wr_busy || |(m_awvalid | m_wvalid)) && k < 200) begin tick(); k++; end
    chk("t6_drained", 32'(wr_busy || |(m_awvalid | m_wvalid)), 32'(0));
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
